pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset. Ports:
- clk  in  1  rising-edge clock, shared with the pipeline registers.
- rst  in  1  synchronous, active-high reset.
- id_rs  in  5  source register A of the instruction in ID.
- id_rt  in  5  source register B of the instruction in ID.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- id_wreg  in  1  ID instruction writes the register file.
- id_m2reg  in  1  ID instruction is a load (result comes from memory).
- id_destR  in  5  destination register of the ID instruction.
- fwda  out  2  operand A select: 00 regfile, 01 EX ALU result, 10 MEM ALU result, 11 MEM load data.
- fwdb  out  2  operand B select, same encoding as fwda.
- stall  out  1  hold PC and the IF/ID register this cycle.
- bubble  out  1  insert all-zero control into the ID/EXE register this cycle.
- stall_cnt  out  16  count of stalled cycles.

Function
REQ-002 The block SHALL keep a shadow pipeline of three slots (EX, MEM, WB), each holding {wreg, m2reg, dest[4:0]}, updated every rising clk edge.
REQ-003 When bubble=0 the EX slot SHALL load {id_wreg, id_m2reg, id_destR}; when bubble=1 it SHALL load all zeros.
REQ-004 On every edge, MEM SHALL load EX and WB SHALL load MEM.
REQ-005 A slot "hits" a source when: the slot's wreg=1, dest≠0, dest equals the source, and the matching use flag is 1.
- Register $0 SHALL never hit.
REQ-006 With forwarding compiled in (see REQ-013), fwdX SHALL be computed combinationally from the current slots and ID inputs, with this priority:
- EX hit with m2reg=0 -> 01;
- else MEM hit with m2reg=0 -> 10;
- else MEM hit with m2reg=1 -> 11;
- else 00.
REQ-007 With forwarding compiled in, stall SHALL be 1 exactly when the EX slot hits rs or rt and has m2reg=1 (load-use). This gives a 1-cycle stall; on the next cycle the producer is in MEM and fwd=11.
REQ-008 bubble SHALL equal stall in every cycle.
REQ-009 If both sources hit different slots, each select SHALL resolve independently.
- Any stall condition on either source SHALL assert stall.
REQ-010 stall_cnt SHALL increment by 1 on each edge where stall=1 and rst=0.
- It SHALL saturate at 16'hFFFF and never wrap.
REQ-011 The outputs fwda, fwdb, stall and bubble SHALL have no internal latency beyond the slot registers: they are combinational from the slots and the ID inputs.

Reset
REQ-012 On an edge with rst=1:
- all slots SHALL clear to zero;
- stall_cnt SHALL clear to zero;
- consequently, in the cycle after reset: fwda=fwdb=00, stall=0, bubble=0.
- A reset during a multi-cycle stall SHALL abort the stall immediately, with no residual bubble.

Configuration
REQ-013 Macro HAZARD_FWD_EN SHALL control forwarding.
- Defined: the behaviour is REQ-006 and REQ-007.
- Undefined: fwda and fwdb SHALL be tied to 00.
- Undefined: stall SHALL be 1 whenever any of the EX, MEM or WB slots hits rs or rt, regardless of m2reg. This gives up to 3 stall cycles per dependency.

Verification
REQ-014 The bench SHALL cover at least the following scenarios, each with HAZARD_FWD_EN defined unless stated otherwise:
- add $3 followed by sub using rs=$3: next cycle fwda=01 and stall=0; with a nop between the two instructions, fwda=10.
- lw $5 followed by add using rt=$5: stall=1 and bubble=1 for exactly 1 cycle, then fwdb=11 and stall=0; stall_cnt increases by 1.
- Producer writes $0 and consumer reads $0: fwda=00 and stall=0 in all cycles.
- EX and MEM both write $7 and consumer reads $7: fwda=01 (EX has priority).
- HAZARD_FWD_EN undefined, add $4 followed by a reader of $4: stall=1 for 3 consecutive cycles, fwda stays 00, and stall_cnt=3.
- rst asserted during the second cycle of a non-forwarding stall: stall=0 on the next cycle and stall_cnt=0; preload stall_cnt to FFFF, apply another stall, and check it holds FFFF.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard control: shadow EX/MEM/WB slots, forwarding selects and stall/bubble.
// Forwarding is compiled in with HAZARD_FWD_EN; otherwise hazards stall until WB drains.
module pipe_hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        id_wreg,
    input  logic        id_m2reg,
    input  logic [4:0]  id_destR,
    output logic [1:0]  fwda,
    output logic [1:0]  fwdb,
    output logic        stall,
    output logic        bubble,
    output logic [15:0] stall_cnt
);

    typedef struct packed {
        logic       wreg;
        logic       m2reg;
        logic [4:0] dest;
    } slot_t;

    slot_t ex_q, mem_q, wb_q;

    function automatic logic hit(input slot_t s, input logic [4:0] src,
                                 input logic use_f);
        return use_f && s.wreg && (s.dest != 5'd0) && (s.dest == src);
    endfunction

    logic ex_ha, ex_hb, mem_ha, mem_hb;

    assign ex_ha  = hit(ex_q,  id_rs, id_use_rs);
    assign ex_hb  = hit(ex_q,  id_rt, id_use_rt);
    assign mem_ha = hit(mem_q, id_rs, id_use_rs);
    assign mem_hb = hit(mem_q, id_rt, id_use_rt);

`ifdef HAZARD_FWD_EN
    // Nearest producer wins; a load only forwards once its data is in MEM.
    always_comb begin
        fwda = 2'b00;
        if (ex_ha && !ex_q.m2reg)        fwda = 2'b01;
        else if (mem_ha && !mem_q.m2reg) fwda = 2'b10;
        else if (mem_ha)                 fwda = 2'b11;

        fwdb = 2'b00;
        if (ex_hb && !ex_q.m2reg)        fwdb = 2'b01;
        else if (mem_hb && !mem_q.m2reg) fwdb = 2'b10;
        else if (mem_hb)                 fwdb = 2'b11;

        stall = (ex_ha || ex_hb) && ex_q.m2reg;
    end
`else
    logic wb_ha, wb_hb;

    assign wb_ha = hit(wb_q, id_rs, id_use_rs);
    assign wb_hb = hit(wb_q, id_rt, id_use_rt);

    always_comb begin
        fwda  = 2'b00;
        fwdb  = 2'b00;
        stall = ex_ha || ex_hb || mem_ha || mem_hb || wb_ha || wb_hb;
    end
`endif

    assign bubble = stall;

    // WB is only consulted in the non-forwarding build.
    logic unused_wb;
    assign unused_wb = ^wb_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            stall_cnt <= '0;
        end else begin
            ex_q  <= bubble ? slot_t'('0)
                            : slot_t'{id_wreg, id_m2reg, id_destR};
            mem_q <= ex_q;
            wb_q  <= mem_q;
            if (stall && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; scenarios follow the HAZARD_FWD_EN build.
// Inputs change on the falling edge and outputs are checked 1 ns later.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  id_rs = '0;
    logic [4:0]  id_rt = '0;
    logic        id_use_rs = 1'b0;
    logic        id_use_rt = 1'b0;
    logic        id_wreg = 1'b0;
    logic        id_m2reg = 1'b0;
    logic [4:0]  id_destR = '0;
    logic [1:0]  fwda, fwdb;
    logic        stall, bubble;
    logic [15:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    pipe_hazard_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .id_use_rs (id_use_rs),
        .id_use_rt (id_use_rt),
        .id_wreg   (id_wreg),
        .id_m2reg  (id_m2reg),
        .id_destR  (id_destR),
        .fwda      (fwda),
        .fwdb      (fwdb),
        .stall     (stall),
        .bubble    (bubble),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic w,
                       input logic m, input logic [4:0] d);
        @(negedge clk);
        id_rs     = rs;
        id_rt     = rt;
        id_use_rs = urs;
        id_use_rt = urt;
        id_wreg   = w;
        id_m2reg  = m;
        id_destR  = d;
        #1;
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++)
            cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        nop(2);
        rst = 1'b0;
        chk("rst_fwda", 16'(fwda), 16'h0);
        chk("rst_fwdb", 16'(fwdb), 16'h0);
        chk("rst_stall", 16'(stall), 16'h0);
        chk("rst_bubble", 16'(bubble), 16'h0);
        chk("rst_cnt", stall_cnt, 16'h0);

`ifdef HAZARD_FWD_EN
        // add $3 ; sub reads $3
        cyc(1, 2, 1, 1, 1, 0, 3);
        chk("add_stall", 16'(stall), 16'h0);
        cyc(3, 2, 1, 1, 1, 0, 8);
        chk("ex_fwda", 16'(fwda), 16'h1);
        chk("ex_fwdb", 16'(fwdb), 16'h0);
        chk("ex_stall", 16'(stall), 16'h0);
        nop(3);
        // add $3 ; nop ; sub reads $3
        cyc(1, 2, 1, 1, 1, 0, 3);
        nop(1);
        cyc(3, 2, 1, 1, 1, 0, 8);
        chk("mem_fwda", 16'(fwda), 16'h2);
        chk("mem_stall", 16'(stall), 16'h0);
        nop(3);
        // lw $5 ; add reads $5 via rt
        cyc(0, 0, 0, 0, 1, 1, 5);
        chk("lw_stall", 16'(stall), 16'h0);
        cyc(1, 5, 1, 1, 1, 0, 9);
        chk("lu_stall", 16'(stall), 16'h1);
        chk("lu_bubble", 16'(bubble), 16'h1);
        chk("lu_fwdb0", 16'(fwdb), 16'h0);
        cyc(1, 5, 1, 1, 1, 0, 9);
        chk("lu_stall2", 16'(stall), 16'h0);
        chk("lu_bubble2", 16'(bubble), 16'h0);
        chk("lu_fwdb", 16'(fwdb), 16'h3);
        chk("lu_cnt", stall_cnt, 16'd1);
        nop(1);
        chk("lu_cnt_hold", stall_cnt, 16'd1);
        nop(2);
        // $0 never forwards
        cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 1, 1, 0, 0, 0);
        chk("r0_fwda", 16'(fwda), 16'h0);
        chk("r0_stall", 16'(stall), 16'h0);
        cyc(0, 0, 1, 1, 0, 0, 0);
        chk("r0_fwda_mem", 16'(fwda), 16'h0);
        chk("r0_stall_mem", 16'(stall), 16'h0);
        nop(3);
        // EX and MEM both write $7
        cyc(0, 0, 0, 0, 1, 0, 7);
        cyc(0, 0, 0, 0, 1, 0, 7);
        cyc(7, 7, 1, 1, 0, 0, 0);
        chk("prio_fwda", 16'(fwda), 16'h1);
        chk("prio_fwdb", 16'(fwdb), 16'h1);
        nop(3);
        // independent selects, and a cleared use flag
        cyc(0, 0, 0, 0, 1, 0, 1);
        cyc(0, 0, 0, 0, 1, 0, 2);
        cyc(1, 2, 1, 1, 0, 0, 0);
        chk("ind_fwda", 16'(fwda), 16'h2);
        chk("ind_fwdb", 16'(fwdb), 16'h1);
        cyc(0, 0, 0, 0, 1, 0, 6);
        cyc(6, 6, 0, 1, 0, 0, 0);
        chk("use_fwda", 16'(fwda), 16'h0);
        chk("use_fwdb", 16'(fwdb), 16'h1);
        nop(3);
        // reset in a load-use stall
        cyc(0, 0, 0, 0, 1, 1, 5);
        cyc(0, 5, 0, 1, 0, 0, 0);
        chk("rs_stall_pre", 16'(stall), 16'h1);
        rst = 1'b1;
        cyc(0, 5, 0, 1, 0, 0, 0);
        rst = 1'b0;
        chk("rs_stall", 16'(stall), 16'h0);
        chk("rs_bubble", 16'(bubble), 16'h0);
        chk("rs_cnt", stall_cnt, 16'h0);
        nop(3);
        // saturation
        cyc(0, 0, 0, 0, 1, 1, 5);
        cyc(0, 5, 0, 1, 0, 0, 0);
        chk("sat_stall", 16'(stall), 16'h1);
        force dut.stall_cnt = 16'hFFFF;
        cyc(0, 5, 0, 1, 0, 0, 0);
        release dut.stall_cnt;
        chk("sat_cnt", stall_cnt, 16'hFFFF);
        cyc(0, 0, 0, 0, 1, 1, 5);
        cyc(0, 5, 0, 1, 0, 0, 0);
        chk("sat_stall2", 16'(stall), 16'h1);
        nop(1);
        chk("sat_hold", stall_cnt, 16'hFFFF);
`else
        // add $4 ; reader of $4 stalls through EX, MEM and WB
        cyc(0, 0, 0, 0, 1, 0, 4);
        chk("add_stall", 16'(stall), 16'h0);
        cyc(4, 2, 1, 1, 1, 0, 9);
        chk("nf_stall1", 16'(stall), 16'h1);
        chk("nf_bubble1", 16'(bubble), 16'h1);
        chk("nf_fwda1", 16'(fwda), 16'h0);
        cyc(4, 2, 1, 1, 1, 0, 9);
        chk("nf_stall2", 16'(stall), 16'h1);
        chk("nf_fwda2", 16'(fwda), 16'h0);
        cyc(4, 2, 1, 1, 1, 0, 9);
        chk("nf_stall3", 16'(stall), 16'h1);
        chk("nf_fwdb3", 16'(fwdb), 16'h0);
        cyc(4, 2, 1, 1, 1, 0, 9);
        chk("nf_stall4", 16'(stall), 16'h0);
        chk("nf_cnt", stall_cnt, 16'd3);
        nop(3);
        // $0 never stalls
        cyc(0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 1, 0, 0, 0);
            chk("r0_stall", 16'(stall), 16'h0);
            chk("r0_fwda", 16'(fwda), 16'h0);
        end
        nop(3);
        // cleared use flag, then an rt hit from a load
        cyc(0, 0, 0, 0, 1, 0, 6);
        cyc(6, 1, 0, 1, 0, 0, 0);
        chk("use_stall", 16'(stall), 16'h0);
        nop(3);
        cyc(0, 0, 0, 0, 1, 1, 6);
        cyc(0, 6, 0, 1, 0, 0, 0);
        chk("rt_stall", 16'(stall), 16'h1);
        nop(3);
        chk("rt_cnt", stall_cnt, 16'd4);
        // reset in the second stall cycle
        cyc(0, 0, 0, 0, 1, 0, 4);
        cyc(4, 0, 1, 0, 1, 0, 9);
        chk("rs_stall_a", 16'(stall), 16'h1);
        cyc(4, 0, 1, 0, 1, 0, 9);
        chk("rs_stall_b", 16'(stall), 16'h1);
        rst = 1'b1;
        cyc(4, 0, 1, 0, 1, 0, 9);
        rst = 1'b0;
        chk("rs_stall", 16'(stall), 16'h0);
        chk("rs_bubble", 16'(bubble), 16'h0);
        chk("rs_cnt", stall_cnt, 16'h0);
        nop(3);
        // saturation
        cyc(0, 0, 0, 0, 1, 0, 4);
        cyc(4, 0, 1, 0, 0, 0, 0);
        chk("sat_stall", 16'(stall), 16'h1);
        force dut.stall_cnt = 16'hFFFF;
        cyc(4, 0, 1, 0, 0, 0, 0);
        release dut.stall_cnt;
        chk("sat_stall2", 16'(stall), 16'h1);
        chk("sat_cnt", stall_cnt, 16'hFFFF);
        cyc(4, 0, 1, 0, 0, 0, 0);
        chk("sat_stall3", 16'(stall), 16'h1);
        chk("sat_hold", stall_cnt, 16'hFFFF);
        cyc(4, 0, 1, 0, 0, 0, 0);
        chk("sat_done", 16'(stall), 16'h0);
        chk("sat_hold2", stall_cnt, 16'hFFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
